// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution block: B-type func3 encodings,
// controller state encoding and a small target-alignment helper.
package branch_pkg;

    // B-type func3 encodings; 3'd2 and 3'd3 are reserved.
    localparam logic [2:0] BEQ  = 3'd0;
    localparam logic [2:0] BNE  = 3'd1;
    localparam logic [2:0] BLT  = 3'd4;
    localparam logic [2:0] BGE  = 3'd5;
    localparam logic [2:0] BLTU = 3'd6;
    localparam logic [2:0] BGEU = 3'd7;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2
    } br_state_e;

    // A jump target is misaligned when it is not on a 4-byte boundary.
    function automatic logic target_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch comparator: decides taken/illegal from the two source
// operands and func3. Signed compares for BLT/BGE, unsigned for BLTU/BGEU.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      func3,
    output logic            taken,
    output logic            illegal
);

    logic eq_s;
    logic lt_s;
    logic ltu_s;

    assign eq_s  = (rs1 == rs2);
    assign lt_s  = ($signed(rs1) < $signed(rs2));
    assign ltu_s = (rs1 < rs2);

    // Select the comparison result for the encoded condition.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (func3)
            BEQ:     taken = eq_s;
            BNE:     taken = !eq_s;
            BLT:     taken = lt_s;
            BGE:     taken = !lt_s;
            BLTU:    taken = ltu_s;
            BGEU:    taken = !ltu_s;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller for the EX stage. Captures one branch, evaluates
// it for exactly one cycle, reports the outcome and, on a mispredict, holds a
// redirect/flush request towards fetch until it is accepted.
// Optional feature macro: BRANCH_STATS_EN adds branch/mispredict counters.
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int INST_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_func3,
    input  logic [XLEN-1:0] br_rs1,
    input  logic [XLEN-1:0] br_rs2,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    input  logic            br_pred_taken,
    output logic            resolve_valid,
    output logic            resolve_taken,
    output logic            illegal,
    output logic            misalign,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    output logic            flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    br_state_e       state_r;
    br_state_e       next_state_s;

    logic [2:0]      func3_r;
    logic [XLEN-1:0] rs1_r;
    logic [XLEN-1:0] rs2_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] imm_r;
    logic            pred_r;
    logic [XLEN-1:0] redir_pc_r;

    logic            taken_s;
    logic            illegal_s;
    logic [XLEN-1:0] target_s;
    logic            misalign_s;
    logic            redirect_s;
    logic            accept_s;

    assign br_ready = (state_r == IDLE);
    assign accept_s = br_valid && (state_r == IDLE);

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .rs1     (rs1_r),
        .rs2     (rs2_r),
        .func3   (func3_r),
        .taken   (taken_s),
        .illegal (illegal_s)
    );

    // Target selection and outcome classification from the captured branch.
    always_comb begin
        target_s   = pc_r + XLEN'(INST_BYTES);
        misalign_s = 1'b0;
        redirect_s = 1'b0;
        if (taken_s) begin
            target_s = pc_r + imm_r;
        end else begin
            target_s = pc_r + XLEN'(INST_BYTES);
        end
        if (illegal_s) begin
            misalign_s = 1'b0;
            redirect_s = 1'b0;
        end else begin
            misalign_s = taken_s && target_misaligned(target_s[1:0]);
            redirect_s = !misalign_s && (taken_s != pred_r);
        end
    end

    // Next-state decision for the accept / evaluate / redirect sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (br_valid) begin
                    next_state_s = EVAL;
                end else begin
                    next_state_s = IDLE;
                end
            end
            EVAL: begin
                if (redirect_s) begin
                    next_state_s = REDIRECT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            REDIRECT: begin
                if (redir_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = REDIRECT;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Outcome and redirect outputs, decoded from state and captured registers only.
    always_comb begin
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        illegal       = 1'b0;
        misalign      = 1'b0;
        redir_valid   = 1'b0;
        flush         = 1'b0;
        case (state_r)
            EVAL: begin
                illegal       = illegal_s;
                resolve_valid = !illegal_s;
                resolve_taken = !illegal_s && taken_s;
                misalign      = misalign_s;
            end
            REDIRECT: begin
                redir_valid = 1'b1;
                flush       = 1'b1;
            end
            default: begin
                resolve_valid = 1'b0;
                redir_valid   = 1'b0;
            end
        endcase
    end

    assign redir_pc = redir_pc_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Capture the presented branch when it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            func3_r <= 3'd0;
            rs1_r   <= {XLEN{1'b0}};
            rs2_r   <= {XLEN{1'b0}};
            pc_r    <= {XLEN{1'b0}};
            imm_r   <= {XLEN{1'b0}};
            pred_r  <= 1'b0;
        end else if (accept_s) begin
            func3_r <= br_func3;
            rs1_r   <= br_rs1;
            rs2_r   <= br_rs2;
            pc_r    <= br_pc;
            imm_r   <= br_imm;
            pred_r  <= br_pred_taken;
        end else begin
            func3_r <= func3_r;
            rs1_r   <= rs1_r;
            rs2_r   <= rs2_r;
            pc_r    <= pc_r;
            imm_r   <= imm_r;
            pred_r  <= pred_r;
        end
    end

    // Load the corrected PC on entry to REDIRECT; held stable while it is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            redir_pc_r <= {XLEN{1'b0}};
        end else if ((state_r == EVAL) && redirect_s) begin
            redir_pc_r <= target_s;
        end else begin
            redir_pc_r <= redir_pc_r;
        end
    end

`ifdef BRANCH_STATS_EN
    // Count resolved branches and mispredict redirects; both wrap at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else if (state_r == EVAL) begin
            if (!illegal_s) begin
                stat_branches <= stat_branches + 32'd1;
            end else begin
                stat_branches <= stat_branches;
            end
            if (redirect_s) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end else begin
                stat_mispredicts <= stat_mispredicts;
            end
        end else begin
            stat_branches    <= stat_branches;
            stat_mispredicts <= stat_mispredicts;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed branches, a high-level
// outcome model compared every cycle, and literal expectations for key cases.
// Stats checks are active when BRANCH_STATS_EN is defined.
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        rst;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_func3;
    logic [31:0] br_rs1;
    logic [31:0] br_rs2;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic        br_pred_taken;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        illegal;
    logic        misalign;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        flush;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int checks = 0;
    int errors = 0;

    branch_resolve_ctrl #(.XLEN(32), .INST_BYTES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .br_valid      (br_valid),
        .br_ready      (br_ready),
        .br_func3      (br_func3),
        .br_rs1        (br_rs1),
        .br_rs2        (br_rs2),
        .br_pc         (br_pc),
        .br_imm        (br_imm),
        .br_pred_taken (br_pred_taken),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .illegal       (illegal),
        .misalign      (misalign),
        .redir_valid   (redir_valid),
        .redir_ready   (redir_ready),
        .redir_pc      (redir_pc),
        .flush         (flush)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        ill;
        logic        tk;
        logic        mis;
        logic        redir;
        logic [31:0] tgt;
    } outcome_t;

    function automatic outcome_t ref_resolve(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] pc,
                                             input logic [31:0] imm, input logic pred);
        outcome_t o;
        o = '0;
        case (f3)
            3'd0: o.tk = (a == b);
            3'd1: o.tk = (a != b);
            3'd4: o.tk = ($signed(a) <  $signed(b));
            3'd5: o.tk = ($signed(a) >= $signed(b));
            3'd6: o.tk = (a <  b);
            3'd7: o.tk = (a >= b);
            default: o.ill = 1'b1;
        endcase
        o.tgt   = o.tk ? (pc + imm) : (pc + 32'd4);
        o.mis   = !o.ill && o.tk && (o.tgt % 32'd4 != 32'd0);
        o.redir = !o.ill && !o.mis && (o.tk != pred);
        return o;
    endfunction

    logic        started = 1'b0;
    logic        m_eval  = 1'b0;
    logic        m_redir = 1'b0;
    outcome_t    m_out   = '0;
    logic [31:0] m_pc    = 32'd0;
    logic [31:0] m_branches = 32'd0;
    logic [31:0] m_mispred  = 32'd0;

    // Model: a branch is accepted when idle, resolved the next cycle, and a
    // mispredict holds a redirect until fetch takes it.
    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            m_eval <= 1'b0; m_redir <= 1'b0; m_pc <= 32'd0;
            m_branches <= 32'd0; m_mispred <= 32'd0;
        end else if (m_redir) begin
            if (redir_ready) m_redir <= 1'b0;
        end else if (m_eval) begin
            m_eval <= 1'b0;
            if (!m_out.ill) m_branches <= m_branches + 32'd1;
            if (m_out.redir) begin
                m_redir   <= 1'b1;
                m_pc      <= m_out.tgt;
                m_mispred <= m_mispred + 32'd1;
            end
        end else if (br_valid) begin
            m_eval <= 1'b1;
            m_out  <= ref_resolve(br_func3, br_rs1, br_rs2, br_pc, br_imm, br_pred_taken);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output against the model.
    task automatic cycle();
        @(negedge clk);
        if (started) begin
            chk("m_br_ready", {31'd0, br_ready}, {31'd0, !m_eval && !m_redir});
            chk("m_resolve_valid", {31'd0, resolve_valid}, {31'd0, m_eval && !m_out.ill});
            if (m_eval && !m_out.ill) chk("m_resolve_taken", {31'd0, resolve_taken}, {31'd0, m_out.tk});
            chk("m_illegal", {31'd0, illegal}, {31'd0, m_eval && m_out.ill});
            chk("m_misalign", {31'd0, misalign}, {31'd0, m_eval && m_out.mis});
            chk("m_redir_valid", {31'd0, redir_valid}, {31'd0, m_redir});
            chk("m_flush", {31'd0, flush}, {31'd0, m_redir});
            if (m_redir) chk("m_redir_pc", redir_pc, m_pc);
`ifdef BRANCH_STATS_EN
            chk("m_stat_branches", stat_branches, m_branches);
            chk("m_stat_mispredicts", stat_mispredicts, m_mispred);
`endif
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            if (br_ready) break;
            cycle();
        end
        chk("wait_ready_timeout", {31'd0, br_ready}, 32'd1);
    endtask

    // Present one branch; returns at the falling edge of its evaluation cycle.
    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        wait_ready();
        br_valid = 1'b1; br_func3 = f3; br_rs1 = a; br_rs2 = b;
        br_pc = pc; br_imm = imm; br_pred_taken = pred;
        cycle();
        br_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; br_valid = 1'b0; br_func3 = 3'd0; br_rs1 = 32'd0; br_rs2 = 32'd0;
        br_pc = 32'd0; br_imm = 32'd0; br_pred_taken = 1'b0; redir_ready = 1'b1;
        repeat (2) cycle();
        chk("rst_br_ready", {31'd0, br_ready}, 32'd1);
        chk("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
        chk("rst_resolve_valid", {31'd0, resolve_valid}, 32'd0);
        chk("rst_redir_pc", redir_pc, 32'd0);
        rst = 1'b0;
        cycle();

        // 1: BEQ taken, predicted not taken -> redirect held until ready.
        redir_ready = 1'b0;
        send(3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        chk("t1_resolve_valid", {31'd0, resolve_valid}, 32'd1);
        chk("t1_resolve_taken", {31'd0, resolve_taken}, 32'd1);
        cycle();
        chk("t1_redir_valid", {31'd0, redir_valid}, 32'd1);
        chk("t1_redir_pc", redir_pc, 32'h120);
        repeat (2) cycle();
        chk("t1_flush_held", {31'd0, flush}, 32'd1);
        chk("t1_br_ready_low", {31'd0, br_ready}, 32'd0);
        redir_ready = 1'b1;
        cycle();
        chk("t1_redir_drop", {31'd0, redir_valid}, 32'd0);
        chk("t1_br_ready", {31'd0, br_ready}, 32'd1);

        // 2: BLTU not taken vs BLT taken on the same operands.
        send(3'd6, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h40, 1'b1);
        chk("t2_bltu_taken", {31'd0, resolve_taken}, 32'd0);
        cycle();
        chk("t2_redir_pc", redir_pc, 32'h4);
        cycle();
        send(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h40, 1'b1);
        chk("t2_blt_taken", {31'd0, resolve_taken}, 32'd1);
        cycle();
        chk("t2_no_redir", {31'd0, redir_valid}, 32'd0);

        // 3: illegal func3.
        send(3'd2, 32'd1, 32'd1, 32'h80, 32'h10, 1'b0);
        chk("t3_illegal", {31'd0, illegal}, 32'd1);
        chk("t3_no_resolve", {31'd0, resolve_valid}, 32'd0);
        cycle();
        chk("t3_br_ready", {31'd0, br_ready}, 32'd1);
        chk("t3_no_redir", {31'd0, redir_valid}, 32'd0);

        // 4: taken BNE to a misaligned target.
        send(3'd1, 32'd1, 32'd2, 32'h200, 32'h6, 1'b0);
        chk("t4_taken", {31'd0, resolve_taken}, 32'd1);
        chk("t4_misalign", {31'd0, misalign}, 32'd1);
        cycle();
        chk("t4_no_redir", {31'd0, redir_valid}, 32'd0);

        // 5: pending redirect dropped by reset.
        redir_ready = 1'b0;
        send(3'd5, 32'd3, 32'd2, 32'h300, 32'h10, 1'b0);
        repeat (3) cycle();
        chk("t5_redir_pc", redir_pc, 32'h310);
        chk("t5_flush", {31'd0, flush}, 32'd1);
        chk("t5_br_ready", {31'd0, br_ready}, 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t5_redir_valid_rst", {31'd0, redir_valid}, 32'd0);
        chk("t5_br_ready_rst", {31'd0, br_ready}, 32'd1);
        redir_ready = 1'b1;
        cycle();

        // 6: ten resolved branches (3 mispredicts, 1 misaligned) plus one illegal.
        send(3'd0, 32'd1, 32'd1, 32'h0, 32'h8, 1'b1);
        send(3'd1, 32'd1, 32'd1, 32'h0, 32'h8, 1'b0);
        send(3'd4, 32'hFFFF_FFFB, 32'd3, 32'h10, 32'h8, 1'b1);
        send(3'd5, 32'hFFFF_FFFB, 32'd3, 32'h10, 32'h8, 1'b0);
        send(3'd6, 32'd2, 32'd3, 32'h1000, 32'h10, 1'b0);
        send(3'd7, 32'd3, 32'd3, 32'h20, 32'h8, 1'b1);
        send(3'd0, 32'd7, 32'd8, 32'h30, 32'h8, 1'b1);
        send(3'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h8, 1'b0);
        cycle();
        chk("t6_wrap_redir_pc", redir_pc, 32'h4);
        send(3'd1, 32'd1, 32'd0, 32'h40, 32'h2, 1'b0);
        send(3'd7, 32'd0, 32'd1, 32'h50, 32'h8, 1'b0);
        send(3'd3, 32'd0, 32'd0, 32'h60, 32'h8, 1'b0);
        cycle();
        wait_ready();
`ifdef BRANCH_STATS_EN
        chk("t6_stat_branches", stat_branches, 32'd10);
        chk("t6_stat_mispredicts", stat_mispredicts, 32'd3);
`endif
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
